sr_cmd_gen: RTL

- Upstream command stage for sr_ff. Takes two raw, asynchronous, bouncy push-button inputs (set, reset).
- Synchronises and debounces each input, then emits one-cycle s/r command pulses that drive sr_ff.s / sr_ff.r directly.
- Guarantees s and r are never high together, so sr_ff never sees its illegal S=R=1 condition.
- Flags the cases where a conflict was resolved.

---
 rtl/sr_pkg.sv | 20 ++
 rtl/sr_debounce_ch.sv | 90 +++++++++
 rtl/sr_cmd_gen.sv | 68 ++++++
 3 files changed

// File: rtl/sr_pkg.sv
// sr_pkg: shared types and constants for the sr_ff command generator.
//   deb_state_t  - per-channel debounce FSM state encoding
//   SYNC_STAGES  - depth of the input synchroniser chain
//   CH_SET/CH_RST - channel indices into the packed button/rise vectors
//   NUM_CH       - number of button channels
package sr_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } deb_state_t;

   localparam int SYNC_STAGES = 2;
   localparam int NUM_CH      = 2;
   localparam int CH_SET      = 0;
   localparam int CH_RST      = 1;

endpackage

// File: rtl/sr_debounce_ch.sv
// sr_debounce_ch: one button channel. It synchronises a raw, asynchronous,
// bouncy button and debounces it. It emits a one-cycle registered rise pulse
// once per accepted press.
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   btn_in   in  raw button level, asynchronous to clk
//   rise     out one-cycle pulse when a press has been stable DEBOUNCE_CYCLES
module sr_debounce_ch
   import sr_pkg::*;
#(
   parameter  int DEBOUNCE_CYCLES = 4,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync2;
   deb_state_t             state;
   logic [CNT_W-1:0]       cnt;

   // Plain flop chain; only the last stage is considered metastability-safe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync <= '0;
      else          sync <= {sync[SYNC_STAGES-2:0], btn_in};
   end

   assign sync2 = sync[SYNC_STAGES-1];

   // The entry into WAIT_* counts as the first stable sample (cnt=1).
   // The level is therefore accepted on the DEBOUNCE_CYCLES-th consecutive sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE_LOW;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         rise <= 1'b0;
         case (state)
            IDLE_LOW: begin
               if (sync2) begin
                  state <= WAIT_HIGH;
                  cnt   <= CNT_ONE;
               end
            end
            WAIT_HIGH: begin
               if (!sync2) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= HIGH;
                  cnt   <= '0;
                  rise  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            HIGH: begin
               if (!sync2) begin
                  state <= WAIT_LOW;
                  cnt   <= CNT_ONE;
               end
            end
            WAIT_LOW: begin
               // A short low glitch returns to HIGH silently: no second pulse.
               if (sync2) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: command stage in front of sr_ff. Two debounced button channels
// (set, reset) feed a registered arbiter. The arbiter never drives s and r high
// together.
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   set_btn  in  raw set button (async, bouncy)
//   rst_btn  in  raw reset button (async, bouncy)
//   s        out one-cycle set command to sr_ff
//   r        out one-cycle reset command to sr_ff
//   conflict out one-cycle flag: both channels qualified a press together
// Build option: define SR_SET_PRIORITY_EN to make set win a simultaneous press.
// By default, reset wins.
module sr_cmd_gen
   import sr_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic set_btn,
   input  logic rst_btn,
   output logic s,
   output logic r,
   output logic conflict
);

   logic [NUM_CH-1:0] btn;
   logic [NUM_CH-1:0] rise;
   logic              set_rise;
   logic              rst_rise;

   assign btn[CH_SET] = set_btn;
   assign btn[CH_RST] = rst_btn;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sr_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk     (clk),
         .reset_n (reset_n),
         .btn_in  (btn[g]),
         .rise    (rise[g])
      );
   end

   assign set_rise = rise[CH_SET];
   assign rst_rise = rise[CH_RST];

   // The outputs are registered, so s/r/conflict trail rise by one cycle.
   // Each branch masks the loser, so s & r can never both be high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s        <= 1'b0;
         r        <= 1'b0;
         conflict <= 1'b0;
      end else begin
         conflict <= set_rise & rst_rise;
`ifdef SR_SET_PRIORITY_EN
         s        <= set_rise;
         r        <= rst_rise & ~set_rise;
`else
         s        <= set_rise & ~rst_rise;
         r        <= rst_rise;
`endif
      end
   end

endmodule
